// File: rtl/ir_fifo_pkg.sv
// ----------------------------------------------------------------------------
// ir_fifo_pkg
// Default geometry for the IR buffer controller. The values are the same as
// the IR buffer's ADDR_WIDTH, IR_DATA_WIDTH and RAM_DEPTH macros, so the
// controller's parameter defaults match the RAM it sits in front of.
// ----------------------------------------------------------------------------
package ir_fifo_pkg;

  localparam int ADDR_WIDTH    = 4;
  localparam int IR_DATA_WIDTH = 8;
  localparam int RAM_DEPTH     = 1 << ADDR_WIDTH;

endpackage : ir_fifo_pkg

// File: rtl/ir_fifo_ptr.sv
// ----------------------------------------------------------------------------
// ir_fifo_ptr
// Wrapping ADDR_W-bit RAM pointer. The pointer wraps naturally because the
// RAM depth is exactly 2**ADDR_W.
//
// Ports
//   clk    in   1       clock, all state on posedge
//   reset  in   1       synchronous active-high reset to 0
//   clr    in   1       synchronous clear to 0 (flush)
//   inc    in   1       advance pointer by one entry
//   ptr    out  ADDR_W  current pointer value
// ----------------------------------------------------------------------------
module ir_fifo_ptr
  import ir_fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  logic [ADDR_W-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= r_ptr + ADDR_W'(1);
    end
  end

  assign ptr = r_ptr;

endmodule : ir_fifo_ptr

// File: rtl/ir_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// ir_fifo_ctrl
// Write/read controller in front of the IR dual-port buffer RAM (async read).
// The RAM holds DEPTH entries and a registered output stage holds one more,
// so the pair behaves as a DEPTH+1 entry FIFO. There is no bypass: a flit
// accepted at edge N is written at edge N and reaches out_data at edge N+1.
//
// Ports
//   clk        in   1         clock, all state on posedge
//   reset      in   1         synchronous active-high reset
//   flush      in   1         synchronous clear of all queued data
//   in_valid   in   1         upstream flit valid
//   in_data    in   DATA_W    upstream flit
//   in_ready   out  1         flit accepted this cycle
//   wr_cs      out  1         RAM chip select (write port)
//   wr_we      out  1         RAM write enable
//   wr_addr    out  ADDR_W    RAM write address
//   wr_data    out  DATA_W    RAM write data
//   rd_addr    out  ADDR_W    RAM read address
//   rd_data    in   DATA_W    RAM read data (combinational from rd_addr)
//   out_valid  out  1         output register holds a flit
//   out_data   out  DATA_W    head flit, registered
//   out_ready  in   1         downstream accepts the flit
//   count      out  ADDR_W+1  entries held in RAM (output register excluded)
// ----------------------------------------------------------------------------
module ir_fifo_ctrl
  import ir_fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = IR_DATA_WIDTH,
  parameter int DEPTH  = RAM_DEPTH       // must equal 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_cs,
  output logic              wr_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] C_ONE   = (ADDR_W + 1)'(1);

  logic [ADDR_W:0]   r_cnt;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;

  logic              w_full;
  logic              w_empty;
  logic              w_in_ready;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_wr_ptr;
  logic [ADDR_W-1:0] w_rd_ptr;

  assign w_full  = (r_cnt == C_DEPTH);
  assign w_empty = (r_cnt == '0);

  // Full blocks the write even if a pop frees a slot this same cycle; the
  // freed slot becomes visible next cycle. Keeps in_ready off the pop path.
  assign w_in_ready = !reset && !flush && !w_full;
  assign w_push     = in_valid && w_in_ready;

  // Refill the output register whenever it is empty or being drained.
  // During flush the state update below discards this, so out_ready is
  // effectively ignored in that cycle.
  assign w_pop = !w_empty && (!r_out_valid || out_ready);

  ir_fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (w_push),
    .ptr   (w_wr_ptr)
  );

  // The pop is gated by flush here as well so the read pointer clears
  // cleanly instead of racing the clear with an increment.
  ir_fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (w_pop && !flush),
    .ptr   (w_rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (flush) begin
      // Queued flits are dropped; out_data keeps its last value.
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + C_ONE;
        2'b01:   r_cnt <= r_cnt - C_ONE;
        default: r_cnt <= r_cnt;
      endcase

      if (w_pop) begin
        r_out_data  <= rd_data;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Write and read pointers only coincide when the RAM is empty or full, so
  // the write port and the prefetch read never touch the same live entry.
  assign in_ready  = w_in_ready;
  assign wr_cs     = w_push;
  assign wr_we     = w_push;
  assign wr_addr   = w_wr_ptr;
  assign wr_data   = in_data;
  assign rd_addr   = w_rd_ptr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign count     = r_cnt;

endmodule : ir_fifo_ctrl

// File: tb/tb_ir_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ir_fifo_ctrl
// Pairs ir_fifo_ctrl with a 16-entry async-read RAM model. Every accepted
// flit is queued as the expected output; a monitor pops and compares each
// time the DUT completes an output handshake. Directed checks cover reset,
// latency, full/empty boundaries, wrap, flush and a random soak.
// ----------------------------------------------------------------------------
module tb_ir_fifo_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          wr_cs;
  logic          wr_we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem[DP];

  always #5 clk = ~clk;

  ir_fifo_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_cs     (wr_cs),
    .wr_we     (wr_we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  // Behavioural RAM: synchronous write, asynchronous read.
  always @(posedge clk) begin
    if (wr_cs && wr_we) mem[wr_addr] <= wr_data;
  end
  assign rd_data = mem[rd_addr];

  // Scoreboard / monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        n_out++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: unexpected output %h, nothing expected", out_data);
        end else begin
          if (out_data !== exp_q[0]) begin
            errors++;
            $display("FAIL scoreboard: out_data got %h expected %h", out_data, exp_q[0]);
          end else begin
            $display("out  %h", out_data);
          end
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        $display("in   %h @ wr_addr %0d", in_data, wr_addr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int base;
  bit saw_wrap;
  logic [AW-1:0] prev_addr;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b0;

    // Reset held two cycles with in_valid high.
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_cs", wr_cs, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    reset = 1'b0; in_valid = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // Single flit with 1-cycle latency, held while out_ready=0.
    in_valid = 1'b1; in_data = 8'hA5;
    #1;
    chk("single_wr_cs", wr_cs, 1);
    chk("single_wr_we", wr_we, 1);
    chk("single_wr_addr", wr_addr, 0);
    tick();
    in_valid = 1'b0;
    chk("single_count1", count, 1);
    chk("single_no_bypass", out_valid, 0);
    tick();
    chk("single_out_valid", out_valid, 1);
    chk("single_out_data", out_data, 8'hA5);
    chk("single_count0", count, 0);
    tick(); tick();
    chk("single_hold_valid", out_valid, 1);
    chk("single_hold_data", out_data, 8'hA5);
    out_ready = 1'b1;
    tick();
    chk("single_drained", out_valid, 0);
    out_ready = 1'b0;

    // Fill: 17 of 20 flits fit (16 RAM + output register).
    base = n_out;
    for (int i = 1; i <= 20; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("fill_count", count, 16);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_head", out_data, 1);
    out_ready = 1'b1;
    #1;
    chk("fill_ready_still_low", in_ready, 0);
    tick();
    chk("fill_ready_after_pop", in_ready, 1);
    for (int i = 0; i < 16; i++) tick();
    chk("fill_outputs", n_out - base, 17);
    chk("fill_empty_count", count, 0);
    chk("fill_empty_valid", out_valid, 0);

    // Streaming with pointer wrap.
    base = n_out; saw_wrap = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; in_data = DW'(8'h40 + i);
      #1;
      if (i > 0 && prev_addr == 4'd15 && wr_addr == 4'd0) saw_wrap = 1'b1;
      prev_addr = wr_addr;
      tick();
      if (count > 1) chk("stream_count_le1", count, 1);
    end
    chk("stream_rate", n_out - base, 38);
    chk("stream_wrap", saw_wrap, 1);
    in_valid = 1'b0;
    tick(); tick();
    chk("stream_total", n_out - base, 40);

    // Flush with 5 queued in RAM and the output register full.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = DW'(8'h80 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_flush_count", count, 5);
    chk("pre_flush_valid", out_valid, 1);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    #1;
    chk("flush_in_ready", in_ready, 0);
    chk("flush_wr_cs", wr_cs, 0);
    tick();
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_data_kept", out_data, 8'h80);
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    chk("post_flush_latency", out_valid, 0);
    tick();
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_data", out_data, 8'h3C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Random soak.
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = DW'($urandom);
      tick();
      if (count > 16) chk("rand_count_max", count, 16);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 40 && (out_valid || count != 0); k++) tick();
    chk("drain_count", count, 0);
    chk("drain_valid", out_valid, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ir_fifo_ctrl
